// File: rtl/activation_feeder.sv
// Unpacks buffer words into activation vectors and feeds pe_array with a triangular row skew.
// Optional FEEDER_STALL_CNT_EN adds a saturating count of RUN bubbles caused by missing words.
module activation_feeder #(
   parameter int ARRAY_SIZE         = 8,
   parameter int COMPUTE_DATA_WIDTH = 4,
   parameter int BUFFER_WORD_SIZE   = 16,
   parameter int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
   parameter int WORDS_PER_VEC      = ARRAY_SIZE / NUM_COMPUTE_LANES,
   parameter int COUNT_WIDTH        = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [COUNT_WIDTH-1:0]               num_vectors,
   input  logic [BUFFER_WORD_SIZE-1:0]          word_in,
   input  logic                                 word_valid,
   output logic                                 word_ready,
   output logic signed [COMPUTE_DATA_WIDTH-1:0] datas_out [ARRAY_SIZE],
   output logic [ARRAY_SIZE-1:0]                valid_out,
   output logic                                 compute_out,
`ifdef FEEDER_STALL_CNT_EN
   output logic [COUNT_WIDTH-1:0]               stall_cycles,
`endif
   output logic                                 busy,
   output logic                                 done
);

   localparam int W           = COMPUTE_DATA_WIDTH;
   localparam int IdxW        = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
   localparam int DrainCycles = 2 * ARRAY_SIZE - 1;
   localparam int DrainW      = $clog2(DrainCycles + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] num_q, num_d;
   logic [COUNT_WIDTH-1:0] vin_q, vin_d;    // vectors fully gathered
   logic [COUNT_WIDTH-1:0] vout_q, vout_d;  // vectors pushed into the skew head
   logic [IdxW-1:0]        idx_q, idx_d;
   logic                   full_q, full_d;
   logic [DrainW-1:0]      drain_q, drain_d;
   logic [W-1:0]           stage_q [ARRAY_SIZE];
   logic [W-1:0]           stage_d [ARRAY_SIZE];
   logic                   busy_q, compute_q, done_q;

   logic                   accept, last_word;
   logic                   skew_shift, skew_clear, head_valid;
   logic [W-1:0]           head_data [ARRAY_SIZE];

   assign word_ready = (state_q == StRun) && (vin_q < num_q);
   assign accept     = word_valid && word_ready;
   assign last_word  = (idx_q == IdxW'(WORDS_PER_VEC - 1));

   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      vin_d      = vin_q;
      vout_d     = vout_q;
      idx_d      = idx_q;
      full_d     = full_q;
      drain_d    = drain_q;
      stage_d    = stage_q;
      skew_shift = 1'b0;
      skew_clear = 1'b0;
      head_valid = 1'b0;
      for (int e = 0; e < ARRAY_SIZE; e++) head_data[e] = '0;

      case (state_q)
         StIdle: begin
            if (start) begin
               num_d   = num_vectors;
               vin_d   = '0;
               vout_d  = '0;
               idx_d   = '0;
               full_d  = 1'b0;
               drain_d = '0;
               state_d = (num_vectors == '0) ? StDone : StRun;
            end
         end
         StRun, StDrain: begin
            skew_shift = 1'b1;
            // The head takes the pre-edge staging contents; a word landing now may overwrite them.
            if (full_q) begin
               head_valid = 1'b1;
               head_data  = stage_q;
               vout_d     = vout_q + COUNT_WIDTH'(1);
               full_d     = 1'b0;
            end
            if (accept) begin
               for (int e = 0; e < ARRAY_SIZE; e++) begin
                  if (e / NUM_COMPUTE_LANES == int'(idx_q)) begin
                     stage_d[e] = word_in[(e % NUM_COMPUTE_LANES) * W +: W];
                  end
               end
               if (last_word) begin
                  idx_d  = '0;
                  full_d = 1'b1;
                  vin_d  = vin_q + COUNT_WIDTH'(1);
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
            if (state_q == StRun) begin
               if (full_q && (vout_q == num_q - COUNT_WIDTH'(1))) begin
                  state_d = StDrain;
                  drain_d = '0;
               end
            end else begin
               drain_d = drain_q + DrainW'(1);
               if (drain_q == DrainW'(DrainCycles - 1)) state_d = StDone;
            end
         end
         StDone: begin
            skew_clear = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         num_q     <= '0;
         vin_q     <= '0;
         vout_q    <= '0;
         idx_q     <= '0;
         full_q    <= 1'b0;
         drain_q   <= '0;
         busy_q    <= 1'b0;
         compute_q <= 1'b0;
         done_q    <= 1'b0;
         for (int e = 0; e < ARRAY_SIZE; e++) stage_q[e] <= '0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         vin_q     <= vin_d;
         vout_q    <= vout_d;
         idx_q     <= idx_d;
         full_q    <= full_d;
         drain_q   <= drain_d;
         busy_q    <= (state_d != StIdle);
         compute_q <= (state_d == StRun) || (state_d == StDrain);
         done_q    <= (state_d == StDone);
         stage_q   <= stage_d;
      end
   end

   assign busy        = busy_q;
   assign compute_out = compute_q;
   assign done        = done_q;

   // Row r sees the head value after r extra register stages.
   for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
      logic [(r+1)*W-1:0] d_q;
      logic [r:0]         v_q;
      if (r == 0) begin : g_head
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               d_q <= '0;
               v_q <= '0;
            end else if (skew_clear) begin
               d_q <= '0;
               v_q <= '0;
            end else if (skew_shift) begin
               d_q <= head_data[r];
               v_q <= head_valid;
            end
         end
      end else begin : g_chain
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               d_q <= '0;
               v_q <= '0;
            end else if (skew_clear) begin
               d_q <= '0;
               v_q <= '0;
            end else if (skew_shift) begin
               d_q <= {d_q[r*W-1:0], head_data[r]};
               v_q <= {v_q[r-1:0], head_valid};
            end
         end
      end
      assign datas_out[r] = d_q[(r+1)*W-1 -: W];
      assign valid_out[r] = v_q[r];
   end

`ifdef FEEDER_STALL_CNT_EN
   logic [COUNT_WIDTH-1:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if ((state_q == StIdle) && start) begin
         stall_q <= '0;
      end else if ((state_q == StRun) && !full_q && word_ready && !word_valid &&
                   (stall_q != '1)) begin
         stall_q <= stall_q + COUNT_WIDTH'(1);
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_activation_feeder.sv
// Bench for activation_feeder: directed job table, hand-written reset sequences and random jobs
// scored against a per-cycle expectation schedule built from the feeder's timing rules.
module tb_activation_feeder;

   localparam int N    = 8;
   localparam int W    = 4;
   localparam int BW   = 16;
   localparam int L    = BW / W;
   localparam int WPV  = N / L;
   localparam int CW   = 16;
   localparam int MAXC = 512;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [CW-1:0]       num_vectors;
   logic [BW-1:0]       word_in;
   logic                word_valid;
   logic                word_ready;
   logic signed [W-1:0] datas_out [N];
   logic [N-1:0]        valid_out;
   logic                compute_out;
   logic                busy;
   logic                done;
`ifdef FEEDER_STALL_CNT_EN
   logic [CW-1:0]       stall_cycles;
`endif

   activation_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_vectors (num_vectors),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .datas_out   (datas_out),
      .valid_out   (valid_out),
      .compute_out (compute_out),
`ifdef FEEDER_STALL_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          nv;
      int          mode;   // 0: valid held high, 1: toggling, 2: random
      bit          mid;    // pulse start again during RUN
      logic [15:0] w0;
      logic [15:0] w1;
      logic [31:0] rows;   // expected first vector, row i in nibble i
   } job_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0]  exp_d [MAXC][N];
   logic          exp_v [MAXC][N];
   bit            comp_edge [MAXC];
   logic [BW-1:0] job_w [64];
   logic [W-1:0]  stage_m [N];
   logic [W-1:0]  cap [N];
   bit            capd [N];
   int            stall_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset();
      for (int i = 0; i < N; i++) chk("rst_data", $unsigned(datas_out[i]), 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_compute", compute_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", word_ready, 0);
`ifdef FEEDER_STALL_CNT_EN
      chk("rst_stall", stall_cycles, 0);
`endif
   endtask

   // Entered and left 1 time unit after a posedge with the feeder idle.
   task automatic run_job(input int nv, input int mode, input bit mid);
      int acc, total, done_edge, last_c, n, c, dut_hs;
      bit v, ready_m;
      for (int k = 0; k < MAXC; k++) begin
         comp_edge[k] = 1'b0;
         for (int i = 0; i < N; i++) begin
            exp_d[k][i] = '0;
            exp_v[k][i] = 1'b0;
         end
      end
      for (int i = 0; i < N; i++) begin
         cap[i]  = 'x;
         capd[i] = 1'b0;
      end
      total     = nv * WPV;
      acc       = 0;
      dut_hs    = 0;
      stall_m   = 0;
      done_edge = (nv == 0) ? 0 : MAXC + 100;
      last_c    = MAXC + 100;
      num_vectors = CW'(nv);
      start       = 1'b1;
      word_valid  = 1'b0;
      word_in     = BW'($urandom);
      @(posedge clk);
      #1;
      start       = 1'b0;
      num_vectors = CW'($urandom);  // must be ignored after start
      n = 0;
      while (n <= done_edge + 1) begin
         if (n >= MAXC - N - 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL job_timeout: got %0d cycles, expected done by cycle %0d", n, MAXC);
            break;
         end
         ready_m = (acc < total);
         chk("word_ready", word_ready, ready_m);
         chk("busy", busy, n <= done_edge);
         chk("compute_out", compute_out, (nv != 0) && (n < done_edge));
         chk("done", done, n == done_edge);
         for (int i = 0; i < N; i++) begin
            chk("datas_out", $unsigned(datas_out[i]), exp_d[n][i]);
            chk("valid_out", valid_out[i], exp_v[n][i]);
            if (valid_out[i] && !capd[i]) begin
               cap[i]  = datas_out[i];
               capd[i] = 1'b1;
            end
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (n % 2 == 0);
            default: v = ($urandom % 4) != 0;
         endcase
         word_valid = v;
         word_in    = (v && ready_m) ? job_w[acc] : BW'($urandom);
         if (mid && n == 3) begin
            start       = 1'b1;
            num_vectors = CW'(9);
         end else begin
            start = 1'b0;
         end
         if (word_ready && v) dut_hs++;
         if ((nv != 0) && (n <= last_c) && !comp_edge[n] && ready_m && !v) stall_m++;
         if (ready_m && v) begin
            for (int l = 0; l < L; l++) stage_m[(acc % WPV) * L + l] = job_w[acc][l*W +: W];
            acc++;
            if (acc % WPV == 0) begin
               c = n + 1;
               comp_edge[c] = 1'b1;
               for (int i = 0; i < N; i++) begin
                  exp_d[c + 1 + i][i] = stage_m[i];
                  exp_v[c + 1 + i][i] = 1'b1;
               end
               if (acc == total) begin
                  last_c    = c;
                  done_edge = c + 2 * N;
               end
            end
         end
         @(posedge clk);
         n++;
         #1;
      end
      start      = 1'b0;
      word_valid = 1'b0;
      chk("handshakes", dut_hs, total);
`ifdef FEEDER_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, stall_m);
`endif
   endtask

   initial begin
      job_t tbl [6];
      tbl[0] = '{1, 0, 1'b0, 16'h3210, 16'h7654, 32'h76543210};
      tbl[1] = '{1, 0, 1'b0, 16'hF8F8, 16'h8F8F, 32'h8F8FF8F8};
      tbl[2] = '{4, 2, 1'b0, 16'h0F1E, 16'h2D3C, 32'h2D3C0F1E};
      tbl[3] = '{3, 1, 1'b0, 16'h3210, 16'h7654, 32'h76543210};
      tbl[4] = '{0, 0, 1'b0, 16'h0000, 16'h0000, 32'h00000000};
      tbl[5] = '{2, 0, 1'b1, 16'hA5C3, 16'h1E7F, 32'h1E7FA5C3};

      // Reset with random inputs
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start       = 1'($urandom);
         word_valid  = 1'($urandom);
         word_in     = BW'($urandom);
         num_vectors = CW'($urandom);
         @(posedge clk);
      end
      #1;
      chk_reset();
      start      = 1'b0;
      word_valid = 1'b0;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_ready", word_ready, 0);
      chk("idle_busy", busy, 0);

      foreach (tbl[t]) begin
         for (int k = 0; k < 64; k++) job_w[k] = BW'($urandom);
         job_w[0] = tbl[t].w0;
         job_w[1] = tbl[t].w1;
         run_job(tbl[t].nv, tbl[t].mode, tbl[t].mid);
         if (tbl[t].nv != 0) begin
            for (int i = 0; i < N; i++) chk("first_vector_row", cap[i], tbl[t].rows[i*4 +: 4]);
         end
      end

      // Asynchronous reset in the middle of DRAIN
      num_vectors = CW'(1);
      start       = 1'b1;
      word_valid  = 1'b1;
      word_in     = 16'h1111;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 word_in = 16'h2222;
      repeat (5) @(posedge clk);
      #1;
      chk("drain_compute", compute_out, 1);
      chk("drain_row3_valid", valid_out[3], 1);
      word_valid = 1'b0;
      rst        = 1'b0;
      #1;
      chk_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_ready", word_ready, 0);
      chk("post_rst_busy", busy, 0);

      // Reset with half a vector gathered; the next job must start from a clean slate
      num_vectors = CW'(2);
      start       = 1'b1;
      word_valid  = 1'b0;
      @(posedge clk);
      #1;
      start      = 1'b0;
      word_valid = 1'b1;
      word_in    = 16'hAAAA;
      @(posedge clk);
      #1;
      word_valid = 1'b0;
      rst        = 1'b0;
      #1;
      chk_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      job_w[0] = 16'h4321;
      job_w[1] = 16'h8765;
      run_job(1, 2, 1'b0);
      for (int i = 0; i < N; i++) begin
         logic [31:0] want;
         want = 32'h87654321;
         chk("after_abort_row", cap[i], want[i*4 +: 4]);
      end

      // Random jobs
      for (int j = 0; j < 6; j++) begin
         for (int k = 0; k < 64; k++) job_w[k] = BW'($urandom);
         run_job($urandom_range(1, 5), 2, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
